// File: rtl/uart_mult_byte_tx_pkg.sv
// Shared constants for the multi-byte UART link: frame header bytes, FSM states
// and the baud divider derivation also used by uart_mult_byte_rx.
package uart_mult_byte_tx_pkg;

  localparam logic [7:0] FRAME_HEAD0 = 8'h55;
  localparam logic [7:0] FRAME_HEAD1 = 8'hAA;

  // Two header bytes, length, command and checksum wrap the payload.
  localparam int unsigned FRAME_OVERHEAD = 5;

  typedef enum logic {
    StIdle,
    StSend
  } tx_state_e;

  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A new byte may be started on the last cycle of the
// previous stop bit, so back-to-back bytes leave no gap on the line.
module uart_byte_tx #(
  parameter int unsigned BPS_CNT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       byte_start,
  input  logic [7:0] byte_data,
  output logic       txd,
  output logic       byte_busy,
  output logic       byte_done
);

  localparam int unsigned BAUD_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);

  logic [BAUD_W-1:0] r_baud;
  logic [3:0]        r_bit;
  logic [8:0]        r_shift;
  logic              r_busy;
  logic              r_txd;
  logic              w_bit_end;
  logic              w_last;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_last    = r_busy && w_bit_end && (r_bit == 4'd9);

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else if (byte_start && (!r_busy || w_last)) begin
      // Start bit goes out now; shifter holds data bits then the stop bit.
      r_txd   <= 1'b0;
      r_busy  <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= {1'b1, byte_data};
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          r_txd  <= 1'b1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_txd   <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_baud <= r_baud + BAUD_W'(1);
      end
    end
  end

  assign txd       = r_txd;
  assign byte_busy = r_busy;
  assign byte_done = w_last;

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Packet UART transmitter: latches command + payload, frames them as
// 55 AA len cmd payload... checksum, and streams the frame through uart_byte_tx.
module uart_mult_byte_tx
  import uart_mult_byte_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned UART_BPS  = 115200,
  parameter int unsigned PAY_BYTES = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   tx_start,
  input  logic [7:0]             tx_cmd,
  input  logic [8*PAY_BYTES-1:0] tx_payload,
  output logic                   uart_txd,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam int unsigned BPS_CNT     = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned FRAME_BYTES = PAY_BYTES + FRAME_OVERHEAD;
  localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  tx_state_e        r_state;
  logic             r_busy;
  logic             r_done;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_frame [FRAME_BYTES];

  logic             w_accept;
  logic             w_byte_start;
  logic             w_byte_busy;
  logic             w_byte_done;
  logic [7:0]       w_byte_data;
  logic [7:0]       w_csum;
  logic [IDX_W-1:0] w_next_idx;

  assign w_accept   = (r_state == StIdle) && !w_byte_busy && tx_start;
  assign w_next_idx = r_idx + IDX_W'(1);

  // Next byte is handed over on the stop bit's final cycle, so the index
  // update and the serialiser reload happen on the same edge.
  assign w_byte_start = w_accept ||
                        ((r_state == StSend) && w_byte_done && (r_idx != LAST_IDX));
  assign w_byte_data  = (r_state == StIdle) ? FRAME_HEAD0 : r_frame[w_next_idx];

  always_comb begin
    w_csum = 8'(PAY_BYTES) + tx_cmd;
    for (int i = 0; i < PAY_BYTES; i++) begin
      w_csum = w_csum + tx_payload[8*i +: 8];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_accept) begin
      r_frame[0] <= FRAME_HEAD0;
      r_frame[1] <= FRAME_HEAD1;
      r_frame[2] <= 8'(PAY_BYTES);
      r_frame[3] <= tx_cmd;
      for (int i = 0; i < PAY_BYTES; i++) begin
        r_frame[4 + i] <= tx_payload[8*i +: 8];
      end
      r_frame[FRAME_BYTES-1] <= w_csum;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state <= StSend;
            r_busy  <= 1'b1;
            r_idx   <= '0;
          end
        end
        StSend: begin
          if (w_byte_done) begin
            if (r_idx == LAST_IDX) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_idx   <= '0;
            end else begin
              r_idx <= w_next_idx;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  uart_byte_tx #(
    .BPS_CNT(BPS_CNT)
  ) u_byte_tx (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .byte_start(w_byte_start),
    .byte_data (w_byte_data),
    .txd       (uart_txd),
    .byte_busy (w_byte_busy),
    .byte_done (w_byte_done)
  );

  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx: line-level reference model compared every cycle,
// plus a line decoder and run-length recorder checked against literal frames.
module tb_uart_mult_byte_tx;

  localparam int unsigned CLK_FREQ  = 1000;
  localparam int unsigned UART_BPS  = 125;
  localparam int unsigned PAY       = 8;
  localparam int unsigned BPS       = CLK_FREQ / UART_BPS;
  localparam int unsigned FRAME     = PAY + 5;
  localparam int unsigned FRAME_CYC = FRAME * 10 * BPS;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b1;
  logic             tx_start = 1'b0;
  logic [7:0]       tx_cmd = '0;
  logic [8*PAY-1:0] tx_payload = '0;
  logic             uart_txd;
  logic             tx_busy;
  logic             tx_done;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  uart_mult_byte_tx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .PAY_BYTES(PAY)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_start  (tx_start),
    .tx_cmd    (tx_cmd),
    .tx_payload(tx_payload),
    .uart_txd  (uart_txd),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8*FRAME-1:0] mk_frame(input logic [7:0] cmd,
                                                  input logic [8*PAY-1:0] pay);
    logic [8*FRAME-1:0] f;
    int sum;
    sum = PAY + cmd;
    f[7:0]   = 8'h55;
    f[15:8]  = 8'hAA;
    f[23:16] = 8'(PAY);
    f[31:24] = cmd;
    for (int i = 0; i < PAY; i++) begin
      f[32+8*i +: 8] = pay[8*i +: 8];
      sum += pay[8*i +: 8];
    end
    f[8*FRAME-8 +: 8] = 8'(sum % 256);
    return f;
  endfunction

  // Model: a queue of expected line levels, one entry per clock cycle.
  logic               mq[$];
  logic               exp_done = 1'b0;
  logic [8*FRAME-1:0] mf;
  logic               lvl;

  always @(posedge sys_clk) begin
    if (sys_rst_n) begin
      mq.delete();
      exp_done = 1'b0;
    end else begin
      exp_done = (mq.size() == 1);
      if (mq.size() > 0) begin
        void'(mq.pop_front());
      end else if (tx_start) begin
        mf = mk_frame(tx_cmd, tx_payload);
        for (int b = 0; b < FRAME; b++) begin
          for (int k = 0; k < 10; k++) begin
            lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : mf[8*b + k - 1];
            for (int c = 0; c < BPS; c++) mq.push_back(lvl);
          end
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    check("txd", {31'd0, uart_txd}, {31'd0, (mq.size() > 0) ? mq[0] : 1'b1});
    check("busy", {31'd0, tx_busy}, {31'd0, mq.size() > 0});
    check("done", {31'd0, tx_done}, {31'd0, exp_done});
  end

  // Line decoder, run-length recorder and busy/done counters.
  logic [7:0] rxq[$];
  logic       dec_on = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte;
  int         run_lvl[$];
  int         run_len[$];
  int         cur_len = 0;
  logic       cur_lvl = 1'b1;
  int         busy_cyc = 0;
  int         done_cnt = 0;

  always @(negedge sys_clk) begin
    int k;
    if (tx_busy === 1'b1) busy_cyc++;
    if (tx_done === 1'b1) done_cnt++;
    if (sys_rst_n) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (uart_txd === 1'b0) begin
        dec_on  = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % BPS == BPS / 2) begin
        k = dec_cnt / BPS;
        if (k >= 1 && k <= 8) begin
          dec_byte[k-1] = uart_txd;
        end else if (k == 9) begin
          rxq.push_back(dec_byte);
          dec_on = 1'b0;
        end
      end
    end
    if (tx_busy === 1'b1) begin
      if (cur_len > 0 && uart_txd == cur_lvl) begin
        cur_len++;
      end else begin
        if (cur_len > 0) begin
          run_lvl.push_back(int'(cur_lvl));
          run_len.push_back(cur_len);
        end
        cur_lvl = uart_txd;
        cur_len = 1;
      end
    end else if (cur_len > 0) begin
      run_lvl.push_back(int'(cur_lvl));
      run_len.push_back(cur_len);
      cur_len = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] cmd, input logic [8*PAY-1:0] pay);
    tx_cmd     = cmd;
    tx_payload = pay;
    tx_start   = 1'b1;
    tick(1);
    tx_start   = 1'b0;
    tx_cmd     = ~cmd;
    tx_payload = ~pay;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (tx_done !== 1'b1 && n < FRAME_CYC + 50) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, tx_done}, 32'd1);
  endtask

  task automatic check_bytes(input string name, input logic [8*FRAME-1:0] f, input int base);
    for (int i = 0; i < FRAME; i++) begin
      if (base + i < rxq.size()) check(name, {24'd0, rxq[base+i]}, {24'd0, f[8*i +: 8]});
      else check(name, 32'hDEAD, {24'd0, f[8*i +: 8]});
    end
  endtask

  logic [7:0] lit1 [13] = '{8'h55, 8'hAA, 8'h08, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04,
                            8'h05, 8'h06, 8'h07, 8'h08, 8'h2D};

  initial begin
    int low72;
    // Reset, with tx_start held during reset to confirm it is ignored.
    sys_rst_n = 1'b1;
    tx_start  = 1'b1;
    tick(3);
    check("rst_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    sys_rst_n = 1'b0;
    tx_start  = 1'b0;
    tick(2);
    check("start_in_rst", {31'd0, tx_busy}, 32'd0);

    // Basic frame, literal bytes and busy length.
    rxq.delete();
    busy_cyc = 0;
    done_cnt = 0;
    send(8'h01, 64'h0807060504030201);
    wait_done("t1_done");
    check("t1_len", rxq.size(), 32'd13);
    for (int i = 0; i < 13; i++) begin
      if (i < rxq.size()) check("t1_byte", {24'd0, rxq[i]}, {24'd0, lit1[i]});
    end
    tick(3);
    check("t1_busy_cyc", busy_cyc, 32'd1040);
    check("t1_done_cnt", done_cnt, 32'd1);

    // Bit timing on an all-zero payload.
    tick(2);
    run_lvl.delete();
    run_len.delete();
    send(8'h80, '0);
    wait_done("t2_done");
    tick(2);
    check("t2_runs", {31'd0, run_len.size() > 10}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (k < run_len.size()) begin
        check("t2_run_lvl", run_lvl[k], k % 2);
        check("t2_run_len", run_len[k], 32'd8);
      end
    end
    low72 = 0;
    for (int i = 0; i < run_len.size(); i++) begin
      if (run_lvl[i] == 0 && run_len[i] == 72) low72++;
    end
    check("t2_zero_bytes", low72, 32'd8);

    // Checksum wrap.
    rxq.delete();
    send(8'hFF, {PAY{8'hFF}});
    wait_done("t3_done");
    check("t3_csum", (rxq.size() > 12) ? {24'd0, rxq[12]} : 32'hDEAD, 32'hFF);
    check_bytes("t3_byte", mk_frame(8'hFF, {PAY{8'hFF}}), 0);

    // Mid-frame start ignored; start in tx_done cycle chains with no gap.
    tick(2);
    rxq.delete();
    send(8'h11, 64'h8877665544332211);
    tick(300);
    tx_cmd     = 8'h22;
    tx_payload = 64'h0123456789ABCDEF;
    tx_start   = 1'b1;
    tick(1);
    tx_start   = 1'b0;
    wait_done("t4a_done");
    send(8'h33, 64'hF0E1D2C3B4A59687);
    check("t4_no_gap_busy", {31'd0, tx_busy}, 32'd1);
    check("t4_no_gap_txd", {31'd0, uart_txd}, 32'd0);
    wait_done("t4b_done");
    check("t4_len", rxq.size(), 32'd26);
    check_bytes("t4a_byte", mk_frame(8'h11, 64'h8877665544332211), 0);
    check_bytes("t4b_byte", mk_frame(8'h33, 64'hF0E1D2C3B4A59687), FRAME);

    // Reset during byte 5, then a clean frame.
    tick(2);
    send(8'h44, 64'h1122334455667788);
    tick(5 * 10 * BPS + 20);
    sys_rst_n = 1'b1;
    tick(1);
    check("t6_rst_txd", {31'd0, uart_txd}, 32'd1);
    check("t6_rst_busy", {31'd0, tx_busy}, 32'd0);
    check("t6_rst_done", {31'd0, tx_done}, 32'd0);
    sys_rst_n = 1'b0;
    done_cnt  = 0;
    tick(200);
    check("t6_no_done", done_cnt, 32'd0);
    rxq.delete();
    send(8'h5A, 64'hA5A5000012345678);
    wait_done("t6_done");
    check("t6_len", rxq.size(), 32'd13);
    check_bytes("t6_byte", mk_frame(8'h5A, 64'hA5A5000012345678), 0);

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
